// File: rtl/audio_sample_player_pkg.sv
// Shared definitions for the audio sample player: FSM state encoding,
// midscale constant, default sample-period divider and small datapath helpers.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_TICK = 2'b01,
    READ      = 2'b10,
    CAPTURE   = 2'b11
  } state_e;

  localparam logic [15:0] MIDSCALE           = 16'h8000;
  localparam int          DEFAULT_SAMPLE_DIV = 2268;

  // Attenuation is a plain arithmetic shift; negative samples round toward -inf.
  function automatic logic signed [15:0] attenuate(input logic signed [15:0] s,
                                                   input logic        [2:0]  sh);
    return s >>> sh;
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sample_player_if.sv
// FIFO read port between the sample FIFO (slave) and the player (master).
interface audio_sample_player_if;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd;

  modport master (output fifo_rd, input fifo_empty, input fifo_dout);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_dout);
endinterface

// File: rtl/audio_sample_player_sd_dac.sv
// First-order sigma-delta modulator: 16-bit offset-binary input, 1-bit output.
// The carry out of the 16-bit accumulation is the output bit, so the pin
// duty cycle equals din_i / 65536.
module sd_dac_1st (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din_i,
  output logic        dout_o
);

  logic [16:0] acc_q;
  logic [16:0] acc_d;

  assign acc_d  = {1'b0, acc_q[15:0]} + {1'b0, din_i};
  assign dout_o = acc_q[16];

  // Accumulate every cycle; bit 16 of the registered sum is the DAC pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/audio_sample_player.sv
// Audio sample player: pops one signed PCM word from the sample FIFO per
// sample period, attenuates it by a 3-bit shift and drives a 1-bit
// sigma-delta DAC pin. Empty FIFO at a tick is reported as an underrun.
module audio_sample_player
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [2:0]                    volume,
  audio_sample_player_if.master         fifo,
  output logic                          audio_out,
  output logic                          sample_tick,
  output logic                          playing,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt,
  output logic [15:0]                   cur_sample
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   div_q;
  logic signed [15:0] cur_sample_q;
  logic               fifo_rd_q;
  logic               playing_q;
  logic               underrun_q;
  logic [15:0]        underrun_cnt_q;

  logic               tick;
  logic signed [15:0] att;
  logic [15:0]        dac_in;

  // Ticks only exist while waiting; READ/CAPTURE can never reach DIV_LAST
  // because the period is at least four cycles.
  assign tick = (state_q == WAIT_TICK) && (div_q == DIV_LAST);

  // Playback FSM with divider, sample register and underrun counter; all
  // outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      div_q          <= '0;
      cur_sample_q   <= '0;
      fifo_rd_q      <= 1'b0;
      playing_q      <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      fifo_rd_q  <= 1'b0;
      underrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_q        <= '0;
          cur_sample_q <= '0;
          if (enable) begin
            state_q   <= WAIT_TICK;
            playing_q <= 1'b1;
          end
        end
        WAIT_TICK: begin
          if (!enable) begin
            // Stopping wins over a coincident tick: no read, no underrun.
            state_q      <= IDLE;
            div_q        <= '0;
            cur_sample_q <= '0;
            playing_q    <= 1'b0;
          end else if (tick) begin
            div_q <= '0;
            if (fifo.fifo_empty) begin
              underrun_q     <= 1'b1;
              underrun_cnt_q <= sat_inc16(underrun_cnt_q);
            end else begin
              state_q   <= READ;
              fifo_rd_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        READ: begin
          // Always completes so a popped word is never dropped.
          div_q   <= div_q + 1'b1;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          cur_sample_q <= fifo.fifo_dout;
          if (!enable) begin
            state_q   <= IDLE;
            div_q     <= '0;
            playing_q <= 1'b0;
          end else begin
            state_q <= WAIT_TICK;
            div_q   <= div_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign att    = attenuate(cur_sample_q, volume);
  assign dac_in = att ^ MIDSCALE;

  sd_dac_1st u_dac (
    .clk    (clk),
    .rst    (rst),
    .din_i  (dac_in),
    .dout_o (audio_out)
  );

  assign fifo.fifo_rd = fifo_rd_q;
  assign sample_tick  = tick;
  assign playing      = playing_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign cur_sample   = cur_sample_q;

endmodule

// File: tb/tb_audio_sample_player.sv
// Directed bench for audio_sample_player with SAMPLE_DIV=8 and a small FIFO model.
module tb_audio_sample_player;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  volume = 3'd0;
  logic        audio_out, sample_tick, playing, underrun;
  logic [15:0] underrun_cnt, cur_sample;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  audio_sample_player_if fif ();

  audio_sample_player #(.SAMPLE_DIV(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .volume       (volume),
    .fifo         (fif.master),
    .audio_out    (audio_out),
    .sample_tick  (sample_tick),
    .playing      (playing),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .cur_sample   (cur_sample)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears on fifo_dout one cycle after fifo_rd is sampled.
  logic [15:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [15:0] dout_r = 16'h0;
  assign fif.fifo_empty = (rd_ptr == wr_ptr);
  assign fif.fifo_dout  = dout_r;
  always @(posedge clk) begin
    if (fif.fifo_rd && (rd_ptr != wr_ptr)) begin
      dout_r <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [15:0] sample;
    logic [2:0]  vol;
    int          ones;
  } duty_vec_t;
  duty_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; volume = 3'd0;
    wr_ptr = rd_ptr;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (audio_out) ones++;
    end
  endtask

  // Waits (bounded) for fifo_rd at a negedge; returns cycles since t0, or -1.
  task automatic wait_rd(input int t0, output int delta);
    delta = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fif.fifo_rd) begin
        delta = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    int t0, d, ones, pulses, rds;
    vecs[0] = '{16'h4000, 3'd0, 3072};
    vecs[1] = '{16'h4000, 3'd1, 2560};
    vecs[2] = '{16'h4000, 3'd7, 2056};
    vecs[3] = '{16'h8001, 3'd2, 1536};
    vecs[4] = '{16'h0000, 3'd0, 2048};
    vecs[5] = '{16'hC000, 3'd1, 1536};
    vecs[6] = '{16'h8000, 3'd0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_audio_out", {31'd0, audio_out}, 32'd0);
    check("rst_fifo_rd", {31'd0, fif.fifo_rd}, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_tick", {31'd0, sample_tick}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_ucnt", {16'd0, underrun_cnt}, 32'd0);
    check("rst_cur", {16'd0, cur_sample}, 32'd0);
    rst = 1'b0;

    // Idle: midscale gives 50 % duty
    count_ones(4096, ones);
    check("idle_duty", ones, 2048);
    check("idle_div", {16'd0, dut.div_q}, 32'd0);

    // Basic playback
    reset_dut;
    push(16'h1234); push(16'h8001);
    @(negedge clk); enable = 1'b1; t0 = cyc;
    rds = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 7)  check("tick_before", {31'd0, sample_tick}, 32'd0);
      if (i == 8)  check("tick_first", {31'd0, sample_tick}, 32'd1);
      if (i == 2)  check("playing", {31'd0, playing}, 32'd1);
      if (fif.fifo_rd) begin
        rds++;
        if (rds == 1) check("rd1_delay", cyc - t0, 9);
        if (rds == 2) check("rd2_delay", cyc - t0, 17);
      end
      if (i == 11) check("cur_first", {16'd0, cur_sample}, 32'h1234);
      if (i == 19) check("cur_second", {16'd0, cur_sample}, 32'h8001);
    end
    check("basic_rds", rds, 2);
    check("basic_ucnt", {16'd0, underrun_cnt}, 32'd0);

    // Underrun: empty FIFO for 41 sampled edges
    reset_dut;
    @(negedge clk); enable = 1'b1;
    pulses = 0; rds = 0;
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      if (underrun) pulses++;
      if (fif.fifo_rd) rds++;
    end
    check("ur_pulses", pulses, 5);
    check("ur_cnt", {16'd0, underrun_cnt}, 32'd5);
    check("ur_rds", rds, 0);
    check("ur_cur", {16'd0, cur_sample}, 32'd0);

    // Tick coincident with enable fall: IDLE wins
    reset_dut;
    @(negedge clk); enable = 1'b1;
    d = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample_tick) begin d = i; break; end
    end
    check("tickfall_seen", (d >= 0), 1);
    enable = 1'b0;
    @(negedge clk);
    check("tickfall_ucnt", {16'd0, underrun_cnt}, 32'd0);
    check("tickfall_underrun", {31'd0, underrun}, 32'd0);
    check("tickfall_playing", {31'd0, playing}, 32'd0);
    check("tickfall_div", {16'd0, dut.div_q}, 32'd0);

    // Disable mid-transfer
    reset_dut;
    push(16'h5555);
    @(negedge clk); enable = 1'b1; t0 = cyc;
    wait_rd(t0, d);
    check("dis_rd_delay", d, 9);
    enable = 1'b0;
    @(negedge clk);
    check("dis_capture_playing", {31'd0, playing}, 32'd1);
    @(negedge clk);
    check("dis_cur_loaded", {16'd0, cur_sample}, 32'h5555);
    check("dis_idle", {31'd0, playing}, 32'd0);
    @(negedge clk);
    check("dis_cur_cleared", {16'd0, cur_sample}, 32'd0);
    check("dis_div", {16'd0, dut.div_q}, 32'd0);

    // Saturation of the underrun counter
    reset_dut;
    @(negedge clk); enable = 1'b1;
    d = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (underrun) begin d = i; break; end
    end
    check("sat_first_ur", (d >= 0), 1);
    force dut.underrun_cnt_q = 16'hFFFE;
    #1;
    release dut.underrun_cnt_q;
    pulses = 0;
    for (int i = 0; i < 40 && pulses < 3; i++) begin
      @(negedge clk);
      if (underrun) begin
        pulses++;
        if (pulses == 1) check("sat_step1", {16'd0, underrun_cnt}, 32'hFFFF);
      end
    end
    check("sat_pulses", pulses, 3);
    check("sat_final", {16'd0, underrun_cnt}, 32'hFFFF);

    // Reset during READ, then clean restart
    reset_dut;
    push(16'h1111);
    @(negedge clk); enable = 1'b1; t0 = cyc;
    wait_rd(t0, d);
    check("rr_rd_delay", d, 9);
    rst = 1'b1;
    @(negedge clk);
    check("rr_fifo_rd", {31'd0, fif.fifo_rd}, 32'd0);
    check("rr_playing", {31'd0, playing}, 32'd0);
    check("rr_cur", {16'd0, cur_sample}, 32'd0);
    push(16'h2222);
    rst = 1'b0; t0 = cyc;
    wait_rd(t0, d);
    check("rr_restart_delay", d, 9);
    @(negedge clk); @(negedge clk);
    check("rr_restart_cur", {16'd0, cur_sample}, 32'h2222);

    // Duty-cycle table: 4096-cycle windows are exact for these inputs
    for (int v = 0; v < 7; v++) begin
      reset_dut;
      push(vecs[v].sample);
      @(negedge clk); enable = 1'b1;
      repeat (12) @(negedge clk);
      check($sformatf("duty%0d_cur", v), {16'd0, cur_sample}, {16'd0, vecs[v].sample});
      volume = vecs[v].vol;
      @(negedge clk);
      count_ones(4096, ones);
      check($sformatf("duty%0d_ones", v), ones, vecs[v].ones);
      enable = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_sample_player.md
# audio_sample_player

- Consumes the 16-bit sample FIFO filled by the SD-card sample fetcher.
- Pops one word per sample period and applies a 3-bit attenuation.
- Drives a 1-bit first-order sigma-delta DAC pin.
- Reports underruns when the FIFO is empty at a sample tick. FIFO words are signed 16-bit PCM; silence is midscale on the pin.

## Interface
Parameters:
- SAMPLE_DIV, default 2268: clk cycles per sample period (100 MHz / 2268 ≈ 44.1 kHz); legal range 4..65535.
- CNT_W, default 16: width of the sample-period divider counter.

Ports (one clock, `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  play request; level-sensitive
- volume  in  3  attenuation, arithmetic right shift 0..7
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  16  FIFO read data, valid 1 cycle after fifo_rd is sampled
- fifo_rd  out  1  registered FIFO pop strobe, one cycle wide
- audio_out  out  1  sigma-delta bitstream
- sample_tick  out  1  one-cycle pulse at each sample-period boundary
- playing  out  1  high whenever state ≠ IDLE
- underrun  out  1  one-cycle pulse when a tick finds the FIFO empty
- underrun_cnt  out  16  saturating count of underruns since reset
- cur_sample  out  16  last captured raw signed sample

## Operation
- **Reset values:**
  - All outputs are 0.
  - cur_sample is 16'h0000.
  - Divider is 0.
  - Modulator accumulator is 17'h00000.
  - State is IDLE.
- **IDLE:**
  - Divider is held at 0 and no ticks are produced.
  - cur_sample is 0.
  - Enters WAIT_TICK when enable=1.
- **WAIT_TICK:**
  - Divider increments every cycle.
  - When the divider equals SAMPLE_DIV-1, it wraps to 0 and sample_tick pulses.
  - On a tick with fifo_empty=0: go to READ.
  - On a tick with fifo_empty=1: pulse underrun, increment underrun_cnt (saturating at 16'hFFFF), hold cur_sample, stay in WAIT_TICK.
  - If enable=0 in this state: go to IDLE, clearing the divider and cur_sample.
- **READ:** fifo_rd=1 for this single cycle, then go to CAPTURE.
- **CAPTURE:**
  - cur_sample <= fifo_dout.
  - Then go to WAIT_TICK, or to IDLE if enable=0.
  - READ and CAPTURE always complete once entered, so no popped word is lost.
- The divider keeps counting through READ and CAPTURE. Because SAMPLE_DIV≥4, the next tick can never occur before CAPTURE finishes.
- **Attenuation:** att = $signed(cur_sample) >>> volume. Volume changes take effect on the next clk.
- **Modulator, every clk including IDLE:**
  - u = att ^ 16'h8000 (offset binary).
  - acc <= {1'b0, acc[15:0]} + u.
  - audio_out <= acc[16], taken from the new sum.
  - The pin duty cycle therefore equals u/65536.
  - IDLE with cur_sample=0 gives 50 % duty.

## Timing
- Tick in cycle T:
  - fifo_rd high in T+1.
  - fifo_dout sampled at the end of T+2.
  - cur_sample updated and visible in T+3.
- From that point, audio_out reflects the new sample 1 cycle later (T+4).
- The first tick after enable rises comes SAMPLE_DIV cycles after entering WAIT_TICK.
- Tick spacing is exactly SAMPLE_DIV cycles while enable=1.
- fifo_empty is evaluated only in the tick cycle. A FIFO that fills later in the same period is not read until the next tick.
- Simultaneous tick and enable fall in WAIT_TICK: IDLE wins. No read and no underrun are recorded.
- rst mid-operation (READ/CAPTURE): state, divider and cur_sample return to reset values at the next edge, and fifo_rd drops at once.
  - The popped word is discarded; the FIFO is flushed by the system reset.

## Structure
- Shared package audio_pkg holds:
  - state encodings IDLE=2'b00, WAIT_TICK=2'b01, READ=2'b10, CAPTURE=2'b11;
  - MIDSCALE=16'h8000;
  - default SAMPLE_DIV=2268.
- Sub-module sd_dac_1st (16-bit input, 1-bit output, 17-bit accumulator) contains the modulator.
- Divider, FSM, attenuation and underrun counter live in the top.

## Test plan
- **Basic playback:** SAMPLE_DIV=8, FIFO preloaded with 16'h1234 and 16'h8001, enable=1.
  - fifo_rd pulses 9 and 17 cycles after enable.
  - cur_sample becomes 16'h1234, then 16'h8001.
  - underrun_cnt stays 0.
- **Underrun:** SAMPLE_DIV=8, empty FIFO, enable for 40 cycles.
  - 5 underrun pulses, underrun_cnt=5.
  - No fifo_rd; cur_sample stays 0.
- **Duty check:** cur_sample=16'h4000, volume=0.
  - audio_out high in exactly 49152 of 65536 cycles.
  - With volume=1: exactly 40960 of 65536.
- **Disable mid-transfer:** drop enable during READ.
  - CAPTURE still loads the word.
  - Next state IDLE; cur_sample cleared 1 cycle later; divider at 0.
- **Saturation:** force underrun_cnt to 16'hFFFE, then apply 3 underruns.
  - Count ends at 16'hFFFF with no wrap.
- **Reset mid-READ:** assert rst in the READ cycle.
  - fifo_rd=0, state=IDLE and cur_sample=0 at the next edge.
  - Playback restarts cleanly after rst releases.
